// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = {DIV_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One non-restoring division iteration: shift {P,Q} left, add or subtract D
// depending on the sign of the old partial remainder, shift in the new quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   p_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] p_shift;

  // Single add/sub on WIDTH+1 bits; the carry out of the top bit is discarded.
  always_comb begin
    p_shift = {p[WIDTH-1:0], q[WIDTH-1]};
    p_next  = p[WIDTH] ? (p_shift + {1'b0, d}) : (p_shift - {1'b0, d});
    q_next  = {q[WIDTH-2:0], ~p_next[WIDTH]};
  end

endmodule

// File: rtl/seq_div32.sv
// Multi-cycle non-restoring divider (quotient -> LO, remainder -> HI).
// Optional feature macro: SEQ_DIV_SIGNED_EN enables two's-complement divide when sgn=1.
//
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// RUN   | one add/sub step per cycle, WIDTH cycles
// FIX   | remainder correction and sign fix-up, results registered
// DONE  | done pulse, busy low; back to IDLE
module seq_div32
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_t state, state_n;

  logic [WIDTH:0]   p_r, p_step, r_corr;
  logic [WIDTH-1:0] q_r, q_step, d_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_mag, b_mag, r_mag, q_final, r_final;
  logic             unused_rsign;

`ifdef SEQ_DIV_SIGNED_EN
  logic a_neg, b_neg, neg_q, neg_r;

  assign a_neg   = sgn & dividend[WIDTH-1];
  assign b_neg   = sgn & divisor[WIDTH-1];
  assign a_mag   = a_neg ? -dividend : dividend;
  assign b_mag   = b_neg ? -divisor : divisor;
  assign q_final = neg_q ? -q_r : q_r;
  assign r_final = neg_r ? -r_mag : r_mag;

  // Result signs: quotient negative when operand signs differ, remainder follows dividend.
  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && start) begin
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end
  end
`else
  logic unused_sgn;

  assign unused_sgn = sgn;
  assign a_mag      = dividend;
  assign b_mag      = divisor;
  assign q_final    = q_r;
  assign r_final    = r_mag;
`endif

  assign r_corr       = p_r[WIDTH] ? (p_r + {1'b0, d_r}) : p_r;
  assign r_mag        = r_corr[WIDTH-1:0];
  assign unused_rsign = r_corr[WIDTH];

  div_step #(.WIDTH(WIDTH)) u_step (
    .p      (p_r),
    .q      (q_r),
    .d      (d_r),
    .p_next (p_step),
    .q_next (q_step)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: if (start) state_n = (divisor == '0) ? DONE : RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == CW'(1)) state_n = FIX;
      end
      FIX: begin
        busy    = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_r         <= '0;
      q_r         <= '0;
      d_r         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= DIV_ZERO_QUOT;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              p_r <= '0;
              q_r <= a_mag;
              d_r <= b_mag;
              cnt <= CW'(WIDTH);
            end
          end
        end
        RUN: begin
          p_r <= p_step;
          q_r <= q_step;
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          quotient    <= q_final;
          remainder   <= r_final;
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div32.sv
// Scoreboard bench for seq_div32: stimulus pushes expected results, a negedge
// monitor pops and compares on every done pulse.
module tb_seq_div32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sgn;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          nbusy;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   busy_cnt = 0;

  seq_div32 dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .sgn         (sgn),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: counts busy cycles per operation, compares results on done.
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 with q=0x%08h, expected no done", quotient);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("quotient", quotient, e.q);
          check("remainder", remainder, e.r);
          check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
          check("busy_in_done", 32'(busy), 32'd0);
          check("busy_cycles", 32'(busy_cnt), 32'(e.nbusy));
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] eq, input logic [31:0] er, input logic edbz);
    exp_t e;
    e.q     = eq;
    e.r     = er;
    e.dbz   = edbz;
    e.nbusy = (b == 32'd0) ? 0 : 33;
    sb.push_back(e);
    dividend = a;
    divisor  = b;
    sgn      = s;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done in 100 cycles, expected done");
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] eq, input logic [31:0] er, input logic edbz);
    issue(a, b, s, eq, er, edbz);
    wait_done();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_quotient"}, quotient, 32'd0);
    check({tag, "_remainder"}, remainder, 32'd0);
    check({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    sgn      = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Unsigned basics and boundaries.
    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op(32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd0, 1'b0);
    run_op(32'hDEAD_BEEF, 32'h10, 1'b0, 32'h0DEA_DBEE, 32'hF, 1'b0);
    run_op(32'd1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd1234, 1'b0 | 1'b1);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0);

    // sgn=1 cases; expectations depend on whether signed support is built.
    run_op(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0);
`ifdef SEQ_DIV_SIGNED_EN
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
`else
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'd7, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0);
`endif
    run_op(32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);

    // Start while busy is ignored; start in the done cycle is dropped.
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    repeat (9) @(negedge clk);
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done();
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    repeat (40) @(negedge clk);
    check("dropped_start_busy", 32'(busy), 32'd0);
    check("held_quotient", quotient, 32'd14);
    run_op(32'd81, 32'd9, 1'b0, 32'd9, 32'd0, 1'b0);

    // Reset mid-RUN aborts with no done pulse.
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check_reset_outputs("abort");
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_quotient_held", quotient, 32'd0);
    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
